lb_arbiter: RTL and testbench
=============================

// Module: lb_arbiter
// PURPOSE
//  Two-requester round-robin arbiter for the shared localbus register map
//  (lbreg, 8b ctrl / 24b addr / 32b data). Port 0 is the UART localbus,
//  port 1 is the UDP localbus. The block serialises their transactions onto
//  the single downstream bus, returns read data or a timeout error to the
//  owning requester, and sits between the host interfaces and qubichw_config.
// PARAMETERS
//  LBCWIDTH  8             ctrl width; ctrl[0]=1 means read, 0 means write
//  LBAWIDTH  24            address width
//  LBDWIDTH  32            data width
//  TIMEOUT   256           max cycles in WAIT for lb_rvalid (>=2)
//  ERR_DATA  32'hDEADBEEF  rdata returned on a read timeout
// PORTS
//  clk                  in   1         system clock
//  rstn                 in   1         async active-low reset
//  m0_req / m1_req      in   1         request; hold with fields until ack
//  m0_ctrl / m1_ctrl    in   LBCWIDTH  request ctrl
//  m0_addr / m1_addr    in   LBAWIDTH  request address
//  m0_wdata / m1_wdata  in   LBDWIDTH  write data
//  m0_ack / m1_ack      out  1         1-cycle completion pulse
//  m0_rdata / m1_rdata  out  LBDWIDTH  read data; valid while ack is high
//  m0_err / m1_err      out  1         timeout flag; valid while ack is high
//  lb_valid             out  1         1-cycle downstream strobe
//  lb_ctrl              out  LBCWIDTH  downstream ctrl (latched)
//  lb_addr              out  LBAWIDTH  downstream address (latched)
//  lb_wdata             out  LBDWIDTH  downstream write data (latched)
//  lb_rdata             in   LBDWIDTH  downstream read data
//  lb_rvalid            in   1         downstream read-data strobe
//  owner                out  1         index of the current or last granted port
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain.
//  - rstn low asynchronously forces: state=IDLE; every output 0; last=1
//    (port 0 wins the first tie); timer cleared.
//  - Reset mid-transaction aborts the transaction; no ack is issued for it.
//  FSM: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE
//  - IDLE: if exactly one req is high, grant that port. If both are high,
//    grant the port != last. Latch ctrl/addr/wdata and set owner, then go
//    to ISSUE. With no req, stay in IDLE.
//  - ISSUE: lb_valid=1 for exactly one cycle with the latched fields.
//    Write (ctrl[0]=0) -> DONE. Read -> WAIT with timer=0.
//  - WAIT: lb_rvalid=1 -> capture lb_rdata, err=0, go to DONE.
//    Otherwise increment timer; timer==TIMEOUT-1 -> rdata=ERR_DATA, err=1,
//    go to DONE.
//  - DONE: owner's ack=1 for one cycle, with rdata/err driven; the other
//    port's ack/rdata/err stay 0. Set last=owner, go to IDLE.
//  Latency
//  - Arbitration cost between back-to-back transactions is >=1 IDLE cycle.
//  - Write: req sampled in cycle 0; lb_valid in cycle 1; ack in cycle 2.
//  - Read with slave latency L>=1 (rvalid L cycles after lb_valid):
//    ack at cycle 2+L.
//  Boundary cases
//  - lb_rvalid outside WAIT is ignored. Consequence: a slave with L=0 always
//    times out.
//  - rdata and err are 0 on write acks and whenever ack is low.
//  - Requester protocol: drop req in the cycle after ack, or keep it high to
//    queue the next request. If the other port is waiting, round-robin gives
//    the next grant to the other port.
//  - req dropped mid-transaction: the transaction still completes and ack
//    still pulses.
//  - Request fields that change after grant have no effect (they were
//    latched in IDLE).
//  - Timer width is clog2(TIMEOUT+1) and the timer never wraps.
// TESTING
//  1 m0 write addr 0x000010 data 0x12345678 -> lb_valid at cycle 1 with
//    those fields; m0_ack at cycle 2; m0_err=0; m1_ack stays 0.
//  2 m1 read addr 0x000020, slave returns 0xCAFEF00D at L=3 ->
//    m1_ack at cycle 5 with m1_rdata=0xCAFEF00D and m1_err=0.
//  3 m0 and m1 request together from reset -> m0 granted first, then m1;
//    keep both high -> grants alternate 0,1,0,1.
//  4 read with no lb_rvalid, TIMEOUT=16 -> ack with rdata=0xDEADBEEF and
//    err=1 after exactly 16 WAIT cycles; a later write completes normally.
//  5 rstn pulsed low during WAIT -> all outputs 0 immediately; no ack;
//    a fresh m0 read afterwards completes correctly.
//  6 m1 drops req during ISSUE, and a stray lb_rvalid arrives during IDLE ->
//    m1_ack still pulses; the stray strobe produces no ack.

Source files
------------

// File: rtl/lb_arbiter.sv
// Two-requester round-robin arbiter serialising UART (port 0) and UDP (port 1)
// localbus transactions onto one downstream lbreg bus, with read timeout.
module lb_arbiter #(
  parameter int unsigned LBCWIDTH = 8,
  parameter int unsigned LBAWIDTH = 24,
  parameter int unsigned LBDWIDTH = 32,
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [LBDWIDTH-1:0] ERR_DATA = LBDWIDTH'(32'hDEADBEEF)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                m0_req,
  input  logic [LBCWIDTH-1:0] m0_ctrl,
  input  logic [LBAWIDTH-1:0] m0_addr,
  input  logic [LBDWIDTH-1:0] m0_wdata,
  output logic                m0_ack,
  output logic [LBDWIDTH-1:0] m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic [LBCWIDTH-1:0] m1_ctrl,
  input  logic [LBAWIDTH-1:0] m1_addr,
  input  logic [LBDWIDTH-1:0] m1_wdata,
  output logic                m1_ack,
  output logic [LBDWIDTH-1:0] m1_rdata,
  output logic                m1_err,
  output logic                lb_valid,
  output logic [LBCWIDTH-1:0] lb_ctrl,
  output logic [LBAWIDTH-1:0] lb_addr,
  output logic [LBDWIDTH-1:0] lb_wdata,
  input  logic [LBDWIDTH-1:0] lb_rdata,
  input  logic                lb_rvalid,
  output logic                owner
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic                r_last;
  logic [TW-1:0]       r_timer;

  logic                w_any;
  logic                w_gnt;
  logic                w_fin;
  logic                w_fin_err;
  logic [LBDWIDTH-1:0] w_fin_data;

  // On a tie the port that was not served last wins
  assign w_any = m0_req | m1_req;
  assign w_gnt = m1_req & (~m0_req | ~r_last);

  // Completion of the current transaction and the result handed back
  always_comb begin
    w_fin      = 1'b0;
    w_fin_data = '0;
    w_fin_err  = 1'b0;
    case (r_state)
      S_ISSUE: w_fin = ~lb_ctrl[0];
      S_WAIT: begin
        if (lb_rvalid) begin
          w_fin      = 1'b1;
          w_fin_data = lb_rdata;
        end else if (r_timer == TLAST) begin
          w_fin      = 1'b1;
          w_fin_data = ERR_DATA;
          w_fin_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_timer  <= '0;
      owner    <= 1'b0;
      lb_valid <= 1'b0;
      lb_ctrl  <= '0;
      lb_addr  <= '0;
      lb_wdata <= '0;
      m0_ack   <= 1'b0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else begin
      // Strobes and ack-qualified results live for a single cycle
      lb_valid <= 1'b0;
      m0_ack   <= 1'b0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
      if (w_fin) begin
        if (owner) begin
          m1_ack   <= 1'b1;
          m1_rdata <= w_fin_data;
          m1_err   <= w_fin_err;
        end else begin
          m0_ack   <= 1'b1;
          m0_rdata <= w_fin_data;
          m0_err   <= w_fin_err;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            owner    <= w_gnt;
            lb_ctrl  <= w_gnt ? m1_ctrl  : m0_ctrl;
            lb_addr  <= w_gnt ? m1_addr  : m0_addr;
            lb_wdata <= w_gnt ? m1_wdata : m0_wdata;
            lb_valid <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= lb_ctrl[0] ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          if (w_fin) r_state <= S_DONE;
          else       r_timer <= r_timer + TW'(1);
        end
        S_DONE: begin
          r_last  <= owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_arbiter.sv
// Bench for lb_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level timing model of the arbiter.
module tb_lb_arbiter;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [CW-1:0] m0_ctrl = '0, m1_ctrl = '0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          lb_valid, lb_rvalid = 1'b0, owner;
  logic [CW-1:0] lb_ctrl;
  logic [AW-1:0] lb_addr;
  logic [DW-1:0] lb_wdata, lb_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  lb_arbiter #(.LBCWIDTH(CW), .LBAWIDTH(AW), .LBDWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_ctrl(m0_ctrl), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_ctrl(m1_ctrl), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .lb_valid(lb_valid), .lb_ctrl(lb_ctrl), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .owner(owner)
  );

  always #5 clk = ~clk;

  wire [133:0] all_outs = {m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata, m1_err,
                           lb_valid, lb_ctrl, lb_addr, lb_wdata, owner};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_ctrl = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_ctrl = '0; m1_addr = '0; m1_wdata = '0;
    lb_rvalid = 0; lb_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    repeat (2) tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_reset();
    m0_req = 1; m1_req = 1; m0_ctrl = 8'hFF; m1_addr = 24'hABCDEF; lb_rvalid = 1;
    rstn = 0;
    #3;
    n_cmp++;
    if (all_outs !== '0) begin n_err++; $display("FAIL reset_assert: got %h want 0", all_outs); end
    repeat (2) tick();
    n_cmp++;
    if (all_outs !== '0) begin n_err++; $display("FAIL reset_held: got %h want 0", all_outs); end
    idle_inputs();
    rstn = 1;
    tick();
    n_cmp++;
    if (all_outs !== '0) begin n_err++; $display("FAIL reset_idle: got %h want 0", all_outs); end
  endtask

  task automatic test_write();
    m0_req = 1; m0_ctrl = 8'h00; m0_addr = 24'h000010; m0_wdata = 32'h12345678;
    tick();
    n_cmp++;
    if ({lb_valid, lb_ctrl, lb_addr, lb_wdata, owner, m0_ack, m1_ack} !==
        {1'b1, 8'h00, 24'h000010, 32'h12345678, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL write_issue: got v=%b c=%h a=%h d=%h o=%b acks=%b%b want 1/00/000010/12345678/0/00",
               lb_valid, lb_ctrl, lb_addr, lb_wdata, owner, m0_ack, m1_ack);
    end
    tick();
    n_cmp++;
    if ({m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, lb_valid} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL write_ack: got ack0=%b err0=%b rd0=%h ack1=%b v=%b want 1/0/0/0/0",
               m0_ack, m0_err, m0_rdata, m1_ack, lb_valid);
    end
    m0_req = 0;
    tick();
    n_cmp++;
    if ({m0_ack, m1_ack, lb_valid} !== 3'b000) begin
      n_err++; $display("FAIL write_after: got %b want 000", {m0_ack, m1_ack, lb_valid});
    end
  endtask

  task automatic test_read();
    logic [33:0] exp1;
    m1_req = 1; m1_ctrl = 8'h01; m1_addr = 24'h000020; m1_wdata = $urandom;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      lb_rvalid = (cyc == 4);
      lb_rdata  = (cyc == 4) ? 32'hCAFEF00D : $urandom;
      if (cyc == 1) begin
        n_cmp++;
        if ({lb_valid, lb_ctrl, lb_addr, owner} !== {1'b1, 8'h01, 24'h000020, 1'b1}) begin
          n_err++; $display("FAIL read_issue: got v=%b c=%h a=%h o=%b", lb_valid, lb_ctrl, lb_addr, owner);
        end
      end
      exp1 = (cyc == 5) ? {1'b1, 32'hCAFEF00D, 1'b0} : 34'h0;
      n_cmp++;
      if ({m1_ack, m1_rdata, m1_err} !== exp1 || m0_ack !== 1'b0) begin
        n_err++; $display("FAIL read_cyc%0d: got ack1=%b rd1=%h err1=%b ack0=%b want %h",
                          cyc, m1_ack, m1_rdata, m1_err, m0_ack, exp1);
      end
      if (cyc == 5) m1_req = 0;
    end
    idle_inputs();
  endtask

  task automatic test_rr();
    logic       exp_v;
    logic       exp_p;
    logic [1:0] exp_acks;
    do_reset();
    m0_req = 1; m0_ctrl = 8'h00; m0_addr = 24'h0000A0; m0_wdata = 32'hA0A0;
    m1_req = 1; m1_ctrl = 8'h00; m1_addr = 24'h0000B1; m1_wdata = 32'hB1B1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      tick();
      exp_v = (cyc % 3 == 1);
      exp_p = (((cyc - 1) / 3) % 2) == 1;
      n_cmp++;
      if (lb_valid !== exp_v) begin
        n_err++; $display("FAIL rr_valid_cyc%0d: got %b want %b", cyc, lb_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (owner !== exp_p || lb_addr !== (exp_p ? 24'h0000B1 : 24'h0000A0)) begin
          n_err++; $display("FAIL rr_grant_cyc%0d: got owner=%b addr=%h want owner=%b", cyc, owner, lb_addr, exp_p);
        end
      end
      exp_acks = (cyc % 3 == 2) ? (((((cyc - 2) / 3) % 2) == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if ({m1_ack, m0_ack} !== exp_acks) begin
        n_err++; $display("FAIL rr_ack_cyc%0d: got %b want %b", cyc, {m1_ack, m0_ack}, exp_acks);
      end
      if (cyc == 11) begin m0_req = 0; m1_req = 0; end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [33:0] exp0;
    m0_req = 1; m0_ctrl = 8'h01; m0_addr = 24'h000033;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      tick();
      lb_rvalid = (cyc == 1);
      lb_rdata  = (cyc == 1) ? 32'h11111111 : 32'h0;
      exp0 = (cyc == 18) ? {1'b1, ERRD, 1'b1} : 34'h0;
      n_cmp++;
      if ({m0_ack, m0_rdata, m0_err} !== exp0 || m1_ack !== 1'b0) begin
        n_err++; $display("FAIL timeout_cyc%0d: got ack0=%b rd0=%h err0=%b want %h",
                          cyc, m0_ack, m0_rdata, m0_err, exp0);
      end
      if (cyc == 18) m0_req = 0;
    end
    m0_req = 1; m0_ctrl = 8'h02; m0_addr = 24'h000044; m0_wdata = 32'h55AA55AA;
    tick();
    n_cmp++;
    if ({lb_valid, lb_ctrl, lb_addr, lb_wdata} !== {1'b1, 8'h02, 24'h000044, 32'h55AA55AA}) begin
      n_err++; $display("FAIL post_timeout_issue: got v=%b a=%h d=%h", lb_valid, lb_addr, lb_wdata);
    end
    tick();
    n_cmp++;
    if ({m0_ack, m0_rdata, m0_err} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL post_timeout_ack: got ack0=%b rd0=%h err0=%b want 1/0/0", m0_ack, m0_rdata, m0_err);
    end
    m0_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [33:0] exp0;
    m0_req = 1; m0_ctrl = 8'h01; m0_addr = 24'h000050;
    repeat (3) tick();
    #2 rstn = 0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin n_err++; $display("FAIL midreset_outs: got %h want 0", all_outs); end
    m0_req = 0;
    repeat (2) tick();
    rstn = 1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      n_cmp++;
      if ({m0_ack, m1_ack, lb_valid} !== 3'b000) begin
        n_err++; $display("FAIL midreset_noack_%0d: got %b want 000", cyc, {m0_ack, m1_ack, lb_valid});
      end
    end
    m0_req = 1; m0_ctrl = 8'h01; m0_addr = 24'h000060;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      lb_rvalid = (cyc == 3);
      lb_rdata  = (cyc == 3) ? 32'h5A5A1234 : $urandom;
      if (cyc == 1) begin
        n_cmp++;
        if ({lb_valid, lb_addr, owner} !== {1'b1, 24'h000060, 1'b0}) begin
          n_err++; $display("FAIL midreset_fresh_issue: got v=%b a=%h o=%b", lb_valid, lb_addr, owner);
        end
      end
      exp0 = (cyc == 4) ? {1'b1, 32'h5A5A1234, 1'b0} : 34'h0;
      n_cmp++;
      if ({m0_ack, m0_rdata, m0_err} !== exp0) begin
        n_err++; $display("FAIL midreset_fresh_cyc%0d: got ack0=%b rd0=%h err0=%b want %h",
                          cyc, m0_ack, m0_rdata, m0_err, exp0);
      end
      if (cyc == 4) m0_req = 0;
    end
    idle_inputs();
  endtask

  task automatic test_drop_stray();
    logic [33:0] exp1;
    m1_req = 1; m1_ctrl = 8'h01; m1_addr = 24'h000044; m1_wdata = 32'h0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 1 || cyc == 2) begin
        n_cmp++;
        if ({lb_valid, lb_ctrl, lb_addr} !== {(cyc == 1), 8'h01, 24'h000044}) begin
          n_err++; $display("FAIL drop_latched_cyc%0d: got v=%b c=%h a=%h", cyc, lb_valid, lb_ctrl, lb_addr);
        end
      end
      if (cyc == 1) begin
        m1_req = 0; m1_ctrl = 8'hFE; m1_addr = 24'hFFFFFF; m1_wdata = $urandom;
      end
      lb_rvalid = (cyc == 3) || (cyc == 6);
      lb_rdata  = (cyc == 3) ? 32'h0BADCAFE : 32'h77777777;
      exp1 = (cyc == 4) ? {1'b1, 32'h0BADCAFE, 1'b0} : 34'h0;
      n_cmp++;
      if ({m1_ack, m1_rdata, m1_err} !== exp1 || m0_ack !== 1'b0 || (cyc > 2 && lb_valid !== 1'b0)) begin
        n_err++; $display("FAIL drop_stray_cyc%0d: got ack1=%b rd1=%h err1=%b ack0=%b v=%b want %h",
                          cyc, m1_ack, m1_rdata, m1_err, m0_ack, lb_valid, exp1);
      end
    end
    idle_inputs();
  endtask

  // Transaction-level model: grant in an idle cycle, issue next cycle, and
  // the ack cycle follows from the op type and the chosen slave latency.
  task automatic test_random(input int ncyc);
    int            c, iss, done_c, rv_c, lat;
    bit            busy, rd, in_wait, eown, last, eerr;
    bit            pend[2];
    bit            gnt[2];
    logic          rq[2];
    logic [CW-1:0] ct[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [CW-1:0] ectrl;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata, erdata, sdata;
    logic [33:0]   e0, e1;
    do_reset();
    c = 0; busy = 0; rd = 0; iss = -1; done_c = -1; rv_c = -1; eown = 0; last = 1; eerr = 0;
    erdata = '0; sdata = '0; ectrl = '0; eaddr = '0; ewdata = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; gnt[p] = 0; rq[p] = 0; ct[p] = '0; ad[p] = '0; wd[p] = '0;
    end
    repeat (ncyc) begin
      in_wait   = busy && rd && (c > iss) && (c < done_c);
      lb_rvalid = (c == rv_c) || (!in_wait && ($urandom_range(0, 7) == 0));
      lb_rdata  = (c == rv_c) ? sdata : $urandom;
      if (busy && c > done_c) busy = 0;
      if (!busy && (m0_req || m1_req)) begin
        eown   = (m0_req && m1_req) ? ~last : m1_req;
        last   = eown;
        ectrl  = eown ? m1_ctrl : m0_ctrl;
        eaddr  = eown ? m1_addr : m0_addr;
        ewdata = eown ? m1_wdata : m0_wdata;
        rd     = ectrl[0];
        iss    = c + 1;
        busy   = 1;
        gnt[eown] = 1;
        if (!rd) begin
          done_c = c + 2; erdata = '0; eerr = 0; rv_c = -1;
        end else begin
          lat = $urandom_range(0, 18);
          sdata = $urandom;
          rv_c = iss + lat;
          if (lat >= 1 && lat <= TO) begin done_c = c + 2 + lat; erdata = sdata; eerr = 0; end
          else begin done_c = c + 2 + TO; erdata = ERRD; eerr = 1; end
        end
      end
      tick();
      c++;
      n_cmp++;
      if (lb_valid !== (busy && c == iss) || owner !== eown) begin
        n_err++; $display("FAIL rand_grant_c%0d: got v=%b o=%b want v=%b o=%b", c, lb_valid, owner, busy && c == iss, eown);
      end
      if (busy && c == iss) begin
        n_cmp++;
        if ({lb_ctrl, lb_addr, lb_wdata} !== {ectrl, eaddr, ewdata}) begin
          n_err++; $display("FAIL rand_fields_c%0d: got %h/%h/%h want %h/%h/%h",
                            c, lb_ctrl, lb_addr, lb_wdata, ectrl, eaddr, ewdata);
        end
      end
      e0 = (busy && c == done_c && !eown) ? {1'b1, erdata, eerr} : 34'h0;
      e1 = (busy && c == done_c &&  eown) ? {1'b1, erdata, eerr} : 34'h0;
      n_cmp++;
      if ({m0_ack, m0_rdata, m0_err} !== e0 || {m1_ack, m1_rdata, m1_err} !== e1) begin
        n_err++; $display("FAIL rand_ack_c%0d: got %b/%h/%b %b/%h/%b want %h %h",
                          c, m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata, m1_err, e0, e1);
      end
      for (int p = 0; p < 2; p++) begin
        if (busy && c == done_c && eown == p[0]) begin pend[p] = 0; gnt[p] = 0; end
        if (gnt[p]) begin
          rq[p] = ($urandom_range(0, 3) != 0);
          ct[p] = $urandom; ad[p] = $urandom; wd[p] = $urandom;
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1; rq[p] = 1;
          ct[p] = $urandom; ad[p] = $urandom; wd[p] = $urandom;
        end else begin
          rq[p] = pend[p];
        end
      end
      m0_req = rq[0]; m0_ctrl = ct[0]; m0_addr = ad[0]; m0_wdata = wd[0];
      m1_req = rq[1]; m1_ctrl = ct[1]; m1_addr = ad[1]; m1_wdata = wd[1];
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rr();
    test_timeout();
    test_reset_mid();
    test_drop_stray();
    test_random(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
